// File: rtl/subcarrier_demux.sv
// OFDM subcarrier demultiplexer: classifies FFT bins from a per-symbol allocation
// vector, buffers data bins through a FIFO and strobes pilot bins out separately.
//
// Ports:
//   CLK_I, RST_I (async, active-low)
//   DAT_I/CYC_I/STB_I/WE_I/ACK_O          upstream bin stream
//   ALLOC_VEC                             2 bits per bin: 00 null, 01 data, 10 pilot, 11 reserved
//   DAT_O/DAT_IDX_O/STB_O/WE_O/CYC_O/ACK_I  downstream data bins (FIFO head)
//   PIL_DAT_O/PIL_IDX_O/PIL_STB_O         pilot strobe port, no backpressure
//   NDATA_O                               data-bin count of the latched vector
//   ERR_O                                 sticky truncated-symbol flag
module subcarrier_demux #(
    parameter int NFFT       = 64,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int IW         = $clog2(NFFT)
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [DW-1:0]     DAT_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    output logic              ACK_O,
    input  logic [2*NFFT-1:0] ALLOC_VEC,
    output logic [DW-1:0]     DAT_O,
    output logic [IW-1:0]     DAT_IDX_O,
    output logic              STB_O,
    output logic              WE_O,
    output logic              CYC_O,
    input  logic              ACK_I,
    output logic [DW-1:0]     PIL_DAT_O,
    output logic [IW-1:0]     PIL_IDX_O,
    output logic              PIL_STB_O,
    output logic [IW:0]       NDATA_O,
    output logic              ERR_O
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [IW-1:0]     idx_q, idx_d;
    logic [2*NFFT-1:0] shadow_q, shadow_d;
    logic [IW:0]       ndata_q, ndata_d;
    logic              err_q, err_d;
    logic              cyc_q, cyc_d;
    logic              pil_stb_q, pil_stb_d;
    logic [DW-1:0]     pil_dat_q, pil_dat_d;
    logic [IW-1:0]     pil_idx_q, pil_idx_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       count_q, count_d;
    logic [DW+IW-1:0]  mem_q [FIFO_DEPTH];

    logic [1:0]        cls;
    logic              is_data, is_pil, full, empty;
    logic              ack, push, pop;
    logic [IW:0]       ndata_pc;
    logic [DW+IW-1:0]  head;
    logic              unused_we;

    assign unused_we = WE_I;

    // Bin 0 classifies straight from the live vector, since the shadow
    // copy is only captured on that same transfer.
    always_comb begin
        if (idx_q == '0) cls = ALLOC_VEC[1:0];
        else             cls = shadow_q[{idx_q, 1'b0} +: 2];
    end

    assign is_data = (cls == 2'b01);
    assign is_pil  = (cls == 2'b10);
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign ack     = CYC_I & STB_I & (~full | ~is_data);
    assign push    = ack & is_data;
    assign pop     = ~empty & ACK_I;

    always_comb begin
        ndata_pc = '0;
        for (int k = 0; k < NFFT; k++) begin
            if (ALLOC_VEC[2*k +: 2] == 2'b01) ndata_pc = ndata_pc + (IW+1)'(1);
        end
    end

    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        ndata_d   = ndata_q;
        err_d     = err_q;
        cyc_d     = cyc_q;
        pil_stb_d = 1'b0;
        pil_dat_d = pil_dat_q;
        pil_idx_d = pil_idx_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;

        if (ack) begin
            idx_d = idx_q + IW'(1);
            if (idx_q == '0) begin
                shadow_d = ALLOC_VEC;
                ndata_d  = ndata_pc;
            end
        end else if (!CYC_I && idx_q != '0) begin
            // Frame ended part-way through a symbol.
            idx_d = '0;
            err_d = 1'b1;
        end

        if (ack && is_pil) begin
            pil_stb_d = 1'b1;
            pil_dat_d = DAT_I;
            pil_idx_d = idx_q;
        end

        if (push) wr_d = wr_q + AW'(1);
        if (pop)  rd_d = rd_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push && pop) count_d = count_q - (AW+1)'(1);

        if (push)                    cyc_d = 1'b1;
        else if (!CYC_I && empty)    cyc_d = 1'b0;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            ndata_q   <= '0;
            err_q     <= 1'b0;
            cyc_q     <= 1'b0;
            pil_stb_q <= 1'b0;
            pil_dat_q <= '0;
            pil_idx_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            ndata_q   <= ndata_d;
            err_q     <= err_d;
            cyc_q     <= cyc_d;
            pil_stb_q <= pil_stb_d;
            pil_dat_q <= pil_dat_d;
            pil_idx_q <= pil_idx_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wr_q] <= {DAT_I, idx_q};
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign head      = empty ? '0 : mem_q[rd_q];
    assign DAT_O     = head[DW+IW-1:IW];
    assign DAT_IDX_O = head[IW-1:0];
    assign STB_O     = ~empty;
    assign WE_O      = ~empty;
    assign CYC_O     = cyc_q;
    assign ACK_O     = ack;
    assign PIL_DAT_O = pil_dat_q;
    assign PIL_IDX_O = pil_idx_q;
    assign PIL_STB_O = pil_stb_q;
    assign NDATA_O   = ndata_q;
    assign ERR_O     = err_q;

endmodule

// File: tb/tb_subcarrier_demux.sv
// Testbench for subcarrier_demux: scoreboard of expected data/pilot words
// against a cycle model of the bin classifier, FIFO and status flags.
module tb_subcarrier_demux;

    localparam int NFFT = 64;
    localparam int DW   = 32;
    localparam int DEP  = 4;
    localparam int IW   = 6;

    logic            CLK_I = 1'b0;
    logic            RST_I;
    logic [DW-1:0]   DAT_I;
    logic            CYC_I, STB_I, WE_I, ACK_O;
    logic [2*NFFT-1:0] ALLOC_VEC;
    logic [DW-1:0]   DAT_O;
    logic [IW-1:0]   DAT_IDX_O;
    logic            STB_O, WE_O, CYC_O, ACK_I;
    logic [DW-1:0]   PIL_DAT_O;
    logic [IW-1:0]   PIL_IDX_O;
    logic            PIL_STB_O;
    logic [IW:0]     NDATA_O;
    logic            ERR_O;

    subcarrier_demux #(.NFFT(NFFT), .DW(DW), .FIFO_DEPTH(DEP)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I),
        .STB_I(STB_I), .WE_I(WE_I), .ACK_O(ACK_O), .ALLOC_VEC(ALLOC_VEC),
        .DAT_O(DAT_O), .DAT_IDX_O(DAT_IDX_O), .STB_O(STB_O), .WE_O(WE_O),
        .CYC_O(CYC_O), .ACK_I(ACK_I), .PIL_DAT_O(PIL_DAT_O),
        .PIL_IDX_O(PIL_IDX_O), .PIL_STB_O(PIL_STB_O), .NDATA_O(NDATA_O),
        .ERR_O(ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2*NFFT-1:0] mk_vec(input bit alt);
        logic [2*NFFT-1:0] v;
        logic [1:0] c;
        v = '0;
        for (int k = 0; k < NFFT; k++) begin
            c = 2'b01;
            if (!alt) begin
                if (k <= 5 || k == 32 || k >= 59) c = 2'b00;
            end else begin
                if (k == 4) c = 2'b10;
                if (k == 5) c = 2'b11;
                if (k == 6) c = 2'b00;
            end
            if (k == 7 || k == 21 || k == 43 || k == 57) c = 2'b10;
            v[2*k +: 2] = c;
        end
        return v;
    endfunction

    function automatic int count_data(input logic [2*NFFT-1:0] v);
        int n = 0;
        for (int k = 0; k < NFFT; k++) if (v[2*k +: 2] == 2'b01) n++;
        return n;
    endfunction

    // Reference model state
    logic [DW+IW-1:0]  dq[$];
    logic [IW-1:0]     idx_m;
    logic [2*NFFT-1:0] shadow_m;
    logic              pil_exp, err_m, cyc_m;
    logic [DW+IW-1:0]  pil_val;
    int                ndata_m;
    int                data_seen, pil_seen;

    always @(negedge CLK_I) begin
        logic [1:0] c;
        logic       a, pu, pp;
        if (!RST_I) begin
            dq.delete();
            idx_m = '0; shadow_m = '0; pil_exp = 0; err_m = 0;
            cyc_m = 0; ndata_m = 0; pil_val = '0;
        end else begin
            c = (idx_m == 0) ? ALLOC_VEC[1:0] : shadow_m[2*idx_m +: 2];
            check("stb", STB_O, dq.size() != 0);
            check("we", WE_O, dq.size() != 0);
            if (dq.size() != 0) check("head", {DAT_O, DAT_IDX_O}, dq[0]);
            check("pil_stb", PIL_STB_O, pil_exp);
            if (pil_exp) begin
                check("pil", {PIL_DAT_O, PIL_IDX_O}, pil_val);
                pil_seen++;
            end
            check("cyc_o", CYC_O, cyc_m);
            check("err", ERR_O, err_m);
            check("ndata", NDATA_O, ndata_m);
            a = CYC_I && STB_I && !(c == 2'b01 && dq.size() == DEP);
            check("ack", ACK_O, a);

            pu = a && c == 2'b01;
            pp = dq.size() != 0 && ACK_I;
            if (pu) cyc_m = 1;
            else if (!CYC_I && dq.size() == 0) cyc_m = 0;
            if (pp) begin
                void'(dq.pop_front());
                data_seen++;
            end
            if (pu) dq.push_back({DAT_I, idx_m});
            pil_exp = a && c == 2'b10;
            pil_val = {DAT_I, idx_m};
            if (a) begin
                if (idx_m == 0) begin
                    shadow_m = ALLOC_VEC;
                    ndata_m  = count_data(ALLOC_VEC);
                end
                idx_m = idx_m + 1'b1;
            end else if (!CYC_I && idx_m != 0) begin
                idx_m = '0;
                err_m = 1;
            end
        end
    end

    task automatic send(input int first, input int n, input int sym);
        logic acc;
        int   w;
        for (int b = first; b < first + n; b++) begin
            DAT_I = (sym << 16) | b;
            CYC_I = 1'b1;
            STB_I = 1'b1;
            w = 0;
            do begin
                @(negedge CLK_I);
                acc = ACK_O;
                @(posedge CLK_I);
                #1;
                w++;
            end while (!acc && w < 200);
            if (!acc) check("send_timeout", 0, 1);
        end
        STB_I = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    initial begin
        logic [2*NFFT-1:0] vec_a, vec_r;
        vec_a = mk_vec(0);
        vec_r = mk_vec(1);
        data_seen = 0; pil_seen = 0;
        RST_I = 1'b0; DAT_I = '0; CYC_I = 0; STB_I = 0; WE_I = 1;
        ACK_I = 0; ALLOC_VEC = vec_a;
        idle(3);
        check("rst_stb", STB_O, 0);
        check("rst_dat", {DAT_O, DAT_IDX_O}, 0);
        check("rst_pil", {PIL_STB_O, PIL_DAT_O, PIL_IDX_O}, 0);
        check("rst_flags", {CYC_O, ERR_O, NDATA_O, ACK_O}, 0);
        RST_I = 1'b1;
        idle(2);

        // Nominal symbol
        ACK_I = 1;
        send(0, 64, 0);
        idle(8);
        check("nom_data", data_seen, 48);
        check("nom_pil", pil_seen, 4);
        check("nom_ndata", NDATA_O, 48);
        check("nom_err", ERR_O, 0);

        // Vector change at bin 30 only affects the next symbol
        send(0, 30, 2);
        ALLOC_VEC = vec_r;
        send(30, 34, 2);
        check("chg_ndata_old", NDATA_O, 48);
        send(0, 64, 3);
        idle(8);
        check("chg_ndata_new", NDATA_O, 57);

        // Backpressure with pilot/reserved/null bins on a full FIFO
        fork
            send(0, 64, 4);
            begin
                ACK_I = 0;
                idle(20);
                ACK_I = 1;
            end
        join
        idle(8);

        // Truncated symbol
        ALLOC_VEC = vec_a;
        send(0, 28, 5);
        ACK_I = 0;
        send(28, 3, 5);
        CYC_I = 0;
        idle(4);
        check("trunc_buf", STB_O, 1);
        ACK_I = 1;
        idle(8);
        check("trunc_err", ERR_O, 1);
        check("trunc_cyc", CYC_O, 0);
        send(0, 10, 6);
        idle(4);

        // Asynchronous reset with three buffered words
        ACK_I = 0;
        send(10, 3, 6);
        check("pre_rst_stb", STB_O, 1);
        @(posedge CLK_I);
        #2 RST_I = 1'b0;
        #1;
        check("arst_stb", {STB_O, WE_O, CYC_O, ERR_O, PIL_STB_O}, 0);
        check("arst_dat", {DAT_O, DAT_IDX_O, NDATA_O}, 0);
        @(posedge CLK_I);
        #1 RST_I = 1'b1;
        ACK_I = 1;
        idle(5);
        check("arst_empty", STB_O, 0);
        send(0, 64, 7);
        idle(8);
        check("final_drain", dq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
